// File: rtl/midi_pkg.sv
// Shared constants, FSM states and voice table entry type for the voice allocator.
package midi_pkg;

  localparam int NUM_VOICES = 16;
  localparam int IDX_W      = 4;
  localparam int AGE_W      = 8;

  localparam logic [7:0] NOTE_LO       = 8'd21;
  localparam logic [7:0] NOTE_HI       = 8'd116;
  localparam logic [3:0] MIDI_NOTE_ON  = 4'h9;
  localparam logic [3:0] MIDI_NOTE_OFF = 4'h8;

  localparam logic [AGE_W-1:0] AGE_ONE = {{(AGE_W-1){1'b0}}, 1'b1};
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    COMMIT
  } state_e;

  typedef struct packed {
    logic             active;
    logic [3:0]       channel;
    logic [7:0]       note;
    logic [AGE_W-1:0] age;
  } voice_entry_t;

  function automatic logic key_eq(input voice_entry_t e, input logic [3:0] ch,
                                  input logic [7:0] note);
    return e.active && (e.channel == ch) && (e.note == note);
  endfunction

endpackage

// File: rtl/voice_select.sv
// Running comparator over the voice table: one entry per enabled cycle, tracking
// first matching voice, lowest free voice and oldest active voice.
module voice_select
  import midi_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [IDX_W-1:0] idx,
  input  voice_entry_t     entry,
  input  logic [3:0]       key_channel,
  input  logic [7:0]       key_note,
  output logic             match_vld,
  output logic [IDX_W-1:0] match_idx,
  output logic             free_vld,
  output logic [IDX_W-1:0] free_idx,
  output logic             old_vld,
  output logic [IDX_W-1:0] old_idx
);

  logic             match_vld_q, match_vld_d;
  logic [IDX_W-1:0] match_idx_q, match_idx_d;
  logic             free_vld_q, free_vld_d;
  logic [IDX_W-1:0] free_idx_q, free_idx_d;
  logic             old_vld_q, old_vld_d;
  logic [IDX_W-1:0] old_idx_q, old_idx_d;
  logic [AGE_W-1:0] old_age_q, old_age_d;

  always_comb begin
    match_vld_d = match_vld_q;
    match_idx_d = match_idx_q;
    free_vld_d  = free_vld_q;
    free_idx_d  = free_idx_q;
    old_vld_d   = old_vld_q;
    old_idx_d   = old_idx_q;
    old_age_d   = old_age_q;
    if (clr) begin
      match_vld_d = 1'b0;
      match_idx_d = '0;
      free_vld_d  = 1'b0;
      free_idx_d  = '0;
      old_vld_d   = 1'b0;
      old_idx_d   = '0;
      old_age_d   = '0;
    end else if (en) begin
      if (!match_vld_q && key_eq(entry, key_channel, key_note)) begin
        match_vld_d = 1'b1;
        match_idx_d = idx;
      end
      if (!free_vld_q && !entry.active) begin
        free_vld_d = 1'b1;
        free_idx_d = idx;
      end
      // Strict compare keeps the lowest index on equal ages (scan is ascending).
      if (entry.active && (!old_vld_q || (entry.age > old_age_q))) begin
        old_vld_d = 1'b1;
        old_idx_d = idx;
        old_age_d = entry.age;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      match_vld_q <= 1'b0;
      match_idx_q <= '0;
      free_vld_q  <= 1'b0;
      free_idx_q  <= '0;
      old_vld_q   <= 1'b0;
      old_idx_q   <= '0;
      old_age_q   <= '0;
    end else begin
      match_vld_q <= match_vld_d;
      match_idx_q <= match_idx_d;
      free_vld_q  <= free_vld_d;
      free_idx_q  <= free_idx_d;
      old_vld_q   <= old_vld_d;
      old_idx_q   <= old_idx_d;
      old_age_q   <= old_age_d;
    end
  end

  assign match_vld = match_vld_q;
  assign match_idx = match_idx_q;
  assign free_vld  = free_vld_q;
  assign free_idx  = free_idx_q;
  assign old_vld   = old_vld_q;
  assign old_idx   = old_idx_q;

endmodule

// File: rtl/voice_allocator.sv
// Note-event sequencer owning the 16-slot voice table: allocates, retriggers or
// steals voices on note-on and silences matching voices on note-off.
module voice_allocator
  import midi_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  evt_valid,
  output logic                  evt_ready,
  input  logic [3:0]            evt_status,
  input  logic [3:0]            evt_channel,
  input  logic [7:0]            evt_note,
  input  logic [7:0]            evt_velocity,
  output logic                  cfg_we,
  output logic [IDX_W-1:0]      cfg_voice,
  output logic [3:0]            cfg_channel,
  output logic [7:0]            cfg_note,
  output logic                  cfg_gate,
  output logic [NUM_VOICES-1:0] active_mask,
  output logic [7:0]            steal_count,
  output logic                  busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VOICES - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] scan_idx_q, scan_idx_d;
  logic             ev_on_q, ev_on_d;
  logic [3:0]       ev_ch_q, ev_ch_d;
  logic [7:0]       ev_note_q, ev_note_d;
  voice_entry_t     table_q [NUM_VOICES];
  voice_entry_t     table_d [NUM_VOICES];
  logic             cfg_we_q, cfg_we_d;
  logic [IDX_W-1:0] cfg_voice_q, cfg_voice_d;
  logic [3:0]       cfg_channel_q, cfg_channel_d;
  logic [7:0]       cfg_note_q, cfg_note_d;
  logic             cfg_gate_q, cfg_gate_d;
  logic [7:0]       steal_count_q, steal_count_d;

  logic             note_ok, is_on, is_off;
  logic             match_vld, free_vld, old_vld;
  logic [IDX_W-1:0] match_idx, free_idx, old_idx;
  logic             have_target, steal;
  logic [IDX_W-1:0] target;

  assign note_ok = (evt_note >= NOTE_LO) && (evt_note <= NOTE_HI);
  assign is_on   = (evt_status == MIDI_NOTE_ON) && (evt_velocity != 8'd0);
  assign is_off  = (evt_status == MIDI_NOTE_OFF) ||
                   ((evt_status == MIDI_NOTE_ON) && (evt_velocity == 8'd0));

  voice_select u_select (
    .clock       (clock),
    .reset       (reset),
    .clr         (state_q == IDLE),
    .en          (state_q == SCAN),
    .idx         (scan_idx_q),
    .entry       (table_q[scan_idx_q]),
    .key_channel (ev_ch_q),
    .key_note    (ev_note_q),
    .match_vld   (match_vld),
    .match_idx   (match_idx),
    .free_vld    (free_vld),
    .free_idx    (free_idx),
    .old_vld     (old_vld),
    .old_idx     (old_idx)
  );

  assign have_target = match_vld || free_vld || old_vld;

  always_comb begin
    steal  = 1'b0;
    target = old_idx;
    if (match_vld) begin
      target = match_idx;
    end else if (free_vld) begin
      target = free_idx;
    end else begin
      steal = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    scan_idx_d    = scan_idx_q;
    ev_on_d       = ev_on_q;
    ev_ch_d       = ev_ch_q;
    ev_note_d     = ev_note_q;
    table_d       = table_q;
    cfg_we_d      = 1'b0;
    cfg_voice_d   = cfg_voice_q;
    cfg_channel_d = cfg_channel_q;
    cfg_note_d    = cfg_note_q;
    cfg_gate_d    = cfg_gate_q;
    steal_count_d = steal_count_q;
    case (state_q)
      IDLE: begin
        // Unclassifiable or out-of-range events are consumed without leaving IDLE.
        if (evt_valid && note_ok && (is_on || is_off)) begin
          state_d    = SCAN;
          scan_idx_d = '0;
          ev_on_d    = is_on;
          ev_ch_d    = evt_channel;
          ev_note_d  = evt_note;
        end
      end
      SCAN: begin
        if (!ev_on_q && key_eq(table_q[scan_idx_q], ev_ch_q, ev_note_q)) begin
          cfg_we_d                     = 1'b1;
          cfg_voice_d                  = scan_idx_q;
          cfg_channel_d                = ev_ch_q;
          cfg_note_d                   = ev_note_q;
          cfg_gate_d                   = 1'b0;
          table_d[scan_idx_q].active   = 1'b0;
        end
        scan_idx_d = scan_idx_q + IDX_W'(1);
        if (scan_idx_q == LAST_IDX) begin
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        state_d = IDLE;
        if (ev_on_q && have_target) begin
          cfg_we_d      = 1'b1;
          cfg_voice_d   = target;
          cfg_channel_d = ev_ch_q;
          cfg_note_d    = ev_note_q;
          cfg_gate_d    = 1'b1;
          if (steal && (steal_count_q != 8'hFF)) begin
            steal_count_d = steal_count_q + 8'd1;
          end
          for (int i = 0; i < NUM_VOICES; i++) begin
            if (IDX_W'(i) == target) begin
              table_d[i].active  = 1'b1;
              table_d[i].channel = ev_ch_q;
              table_d[i].note    = ev_note_q;
              table_d[i].age     = '0;
            end else if (table_q[i].active && (table_q[i].age != AGE_MAX)) begin
              table_d[i].age = table_q[i].age + AGE_ONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      scan_idx_q    <= '0;
      ev_on_q       <= 1'b0;
      ev_ch_q       <= '0;
      ev_note_q     <= '0;
      table_q       <= '{default: '0};
      cfg_we_q      <= 1'b0;
      cfg_voice_q   <= '0;
      cfg_channel_q <= '0;
      cfg_note_q    <= '0;
      cfg_gate_q    <= 1'b0;
      steal_count_q <= '0;
    end else begin
      state_q       <= state_d;
      scan_idx_q    <= scan_idx_d;
      ev_on_q       <= ev_on_d;
      ev_ch_q       <= ev_ch_d;
      ev_note_q     <= ev_note_d;
      table_q       <= table_d;
      cfg_we_q      <= cfg_we_d;
      cfg_voice_q   <= cfg_voice_d;
      cfg_channel_q <= cfg_channel_d;
      cfg_note_q    <= cfg_note_d;
      cfg_gate_q    <= cfg_gate_d;
      steal_count_q <= steal_count_d;
    end
  end

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_mask
    assign active_mask[gi] = table_q[gi].active;
  end

  assign evt_ready   = (state_q == IDLE);
  assign busy        = (state_q != IDLE);
  assign cfg_we      = cfg_we_q;
  assign cfg_voice   = cfg_voice_q;
  assign cfg_channel = cfg_channel_q;
  assign cfg_note    = cfg_note_q;
  assign cfg_gate    = cfg_gate_q;
  assign steal_count = steal_count_q;

endmodule

// File: doc/voice_allocator.md
Name: voice_allocator

Overview:
Sequencer that sits between the MIDI receiver and the polyphonic voice datapath. It accepts decoded note events over a valid/ready handshake and owns the 16-slot voice table. It allocates a free voice on note-on, retriggers a voice already playing the same note, and steals the oldest voice when the table is full. It drives single-cycle configuration writes (voice index, channel, note, gate) into the datapath's per-voice registers.

Parameters:
NUM_VOICES, 16, number of voice slots (power of two)
IDX_W, 4, voice index width, log2(NUM_VOICES)
AGE_W, 8, per-voice age counter width (saturating)
NOTE_LO, 21, lowest playable MIDI note (first inc-rate table entry)
NOTE_HI, 116, highest playable MIDI note (NOTE_LO + 95)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
evt_valid  in  1  event present
evt_ready  out  1  allocator can accept an event
evt_status  in  4  MIDI status nibble (0x9 on, 0x8 off)
evt_channel  in  4  MIDI channel
evt_note  in  8  MIDI note number
evt_velocity  in  8  MIDI velocity
cfg_we  out  1  one-cycle voice config write strobe
cfg_voice  out  IDX_W  target voice
cfg_channel  out  4  channel to store
cfg_note  out  8  note to store
cfg_gate  out  1  1 = start/retrigger voice, 0 = silence voice
active_mask  out  NUM_VOICES  bit i = voice i gated on
steal_count  out  8  saturating count of voice steals
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset low, async): FSM=IDLE. All voice entries cleared (active=0, channel=0, note=0, age=0). cfg_* outputs=0, active_mask=0, steal_count=0, evt_ready=1, busy=0. Reset mid-scan aborts the event with no write.
- Handshake: event accepted on the rising edge where evt_valid && evt_ready. evt_ready=1 only in IDLE. Event fields are latched at accept. Inputs may change afterwards.
- Classification at accept:
  - status 0x9 with velocity != 0 → NOTE_ON.
  - status 0x8, or 0x9 with velocity 0 → NOTE_OFF.
  - Any other status, or note outside NOTE_LO..NOTE_HI → dropped. FSM stays IDLE, evt_ready stays 1, no write.
- States: IDLE → SCAN (NUM_VOICES cycles, scan_idx 0..NUM_VOICES-1, one entry per cycle) → COMMIT (1 cycle) → IDLE.
- Latency: accept at edge T. SCAN covers T+1..T+16. COMMIT at T+17. evt_ready high again at T+18.
- SCAN for NOTE_ON, tracked per entry:
  - match: first entry that is active with equal channel and note.
  - free: lowest-index inactive entry.
  - oldest: active entry with maximum age. Ties go to the lowest index.
- COMMIT for NOTE_ON:
  - Target priority: match, else free, else oldest. A steal increments steal_count, saturating at 255.
  - cfg_we=1 for exactly this cycle, with cfg_voice=target, cfg_channel/cfg_note=latched values, cfg_gate=1.
  - Target entry: active=1, age=0.
  - Every other active entry: age+1, saturating at 2^AGE_W-1.
- SCAN for NOTE_OFF:
  - Each active entry with equal channel and note gets cfg_we=1, cfg_gate=0, cfg_voice=scan_idx in that scan cycle.
  - The entry is cleared to active=0 on the same edge.
  - Multiple matches produce multiple strobes. No match produces no strobe.
  - COMMIT does nothing for NOTE_OFF. Ages are not changed.
- cfg_* are registered outputs. cfg_we is low in every cycle not listed above. cfg_channel, cfg_note and cfg_voice hold their last value when cfg_we=0.
- active_mask reflects the table combinationally from registered state. It updates the cycle after a write.
- An event arriving while busy stays pending on evt_valid. The allocator does not drop it.

Decomposition:
- Shared package midi_pkg holds:
  - constants MIDI_NOTE_ON=4'h9, MIDI_NOTE_OFF=4'h8, NOTE_LO, NOTE_HI;
  - state enum {IDLE, SCAN, COMMIT};
  - voice_entry struct {active, channel[3:0], note[7:0], age[AGE_W-1:0]}.
- One natural sub-module: voice_select, a registered running comparator. Per scan cycle it updates best-match, first-free and oldest indices and their valid flags. It is reset at the start of SCAN.

Test Plan:
- Reset, then NOTE_ON ch0 note 60 vel 100. Required: evt_ready low T+1..T+17; cfg_we at T+17 with voice 0, note 60, gate 1; active_mask=0x0001.
- 16 NOTE_ONs, notes 60..75, then note 80. Required: 17th write targets voice 0 (oldest, age 15); steal_count=1; cfg_note=80.
- Voices 0 and 1 hold ch0/60 and ch0/62. Send NOTE_ON ch0 62. Required: retrigger of voice 1 (not voice 2), gate 1, voice 1 age reset to 0, active_mask unchanged at 0x0003.
- Voice 3 holds ch2/64. Send status 0x9 ch2 note 64 vel 0. Required: exactly one cfg_we, during scan cycle T+4, with voice 3, gate 0; active_mask bit 3 cleared.
- Send status 0xB, then a note-on with note 10. Required: no cfg_we; evt_ready stays 1; busy stays 0.
- Assert reset at T+8 of a NOTE_ON scan. Required: cfg_we never pulses; outputs return to reset values immediately; the next event is accepted normally after reset is released.
